// File: rtl/psram_word32_bridge_pkg.sv
// psram_word32_bridge_pkg: shared states, halfword selectors and default parameters for the word bridge
package psram_word32_bridge_pkg;
  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_LO_WAIT, RD_HI, RD_HI_WAIT, RESP} state_t;
  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;
  localparam int RD_LATENCY_DEFAULT = 4;
  localparam int ADDRESS_BITS_DEFAULT = 23;
endpackage

// File: rtl/psram_word32_bridge_if.sv
// psram_word32_bridge_if: upstream 32-bit word request/response bus
interface psram_word32_bridge_if
  import psram_word32_bridge_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEFAULT
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDRESS_BITS-2:0] req_address;
  logic [31:0] req_wdata;
  logic rsp_valid;
  logic [31:0] rsp_data;
  modport master (output req_valid, req_write, req_address, req_wdata, input req_ready, rsp_valid, rsp_data);
  modport slave (input req_valid, req_write, req_address, req_wdata, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/psram_word32_bridge.sv
// psram_word32_bridge: splits 32-bit word requests into low-then-high 16-bit PSRAM controller accesses
module psram_word32_bridge
  import psram_word32_bridge_pkg::*;
#(
  parameter int ADDRESS_BITS = ADDRESS_BITS_DEFAULT,
  parameter int RD_LATENCY = RD_LATENCY_DEFAULT
) (
  input logic clk,
  input logic reset_n,
  psram_word32_bridge_if.slave bus,
  output logic busy,
  output logic [ADDRESS_BITS-1:0] rd_address,
  output logic rd_en,
  input logic rd_ack,
  input logic [15:0] rd_data,
  output logic [ADDRESS_BITS-1:0] wr_address,
  output logic wr_en,
  output logic [15:0] wr_data,
  input logic wr_ack
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  state_t state, state_n;
  logic [ADDRESS_BITS-2:0] addr;
  logic [31:0] wdata;
  logic [15:0] data_lo;
  logic [31:0] rsp_q;
  logic [CW-1:0] cnt;
  logic half;
  always_ff @(posedge clk)
    state <= !reset_n ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = (bus.req_valid && bus.req_ready) ? (bus.req_write ? WR_LO : RD_LO) : IDLE;
      WR_LO:      state_n = wr_ack ? WR_HI : WR_LO;
      WR_HI:      state_n = wr_ack ? IDLE : WR_HI;
      RD_LO:      state_n = rd_ack ? RD_LO_WAIT : RD_LO;
      RD_LO_WAIT: state_n = (cnt == '0) ? RD_HI : RD_LO_WAIT;
      RD_HI:      state_n = rd_ack ? RD_HI_WAIT : RD_HI;
      RD_HI_WAIT: state_n = (cnt == '0) ? RESP : RD_HI_WAIT;
      RESP:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
      rsp_q <= '0;
    end else begin
      cnt <= (rd_en && rd_ack) ? CW'(RD_LATENCY - 1) : (cnt != '0) ? cnt - 1'b1 : cnt;
      if (bus.req_valid && bus.req_ready) begin
        addr <= bus.req_address;
        wdata <= bus.req_wdata;
      end
      if (state == RD_LO_WAIT && cnt == '0) data_lo <= rd_data;
      if (state == RD_HI_WAIT && cnt == '0) rsp_q <= {rd_data, data_lo};
    end
  end
  assign half = (state == WR_HI || state == RD_HI) ? HALF_HI : HALF_LO;
  assign bus.req_ready = reset_n && state == IDLE;
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_data = rsp_q;
  assign busy = state != IDLE;
  assign rd_en = state == RD_LO || state == RD_HI;
  assign wr_en = state == WR_LO || state == WR_HI;
  assign rd_address = {addr, half};
  assign wr_address = {addr, half};
  assign wr_data = state == WR_HI ? wdata[31:16] : wdata[15:0];
endmodule

// File: tb/tb_psram_word32_bridge.sv
// tb_psram_word32_bridge: directed and random word traffic against a halfword controller model and word reference memory
module tb_psram_word32_bridge;
  localparam int AB = 23;
  localparam int L = 4;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;
  psram_word32_bridge_if #(.ADDRESS_BITS(AB)) bus();
  logic busy, rd_en, wr_en, rd_ack, wr_ack, ack_now;
  logic [AB-1:0] rd_address, wr_address;
  logic [15:0] rd_data, wr_data;
  psram_word32_bridge #(.ADDRESS_BITS(AB), .RD_LATENCY(L)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
    .rd_address(rd_address), .rd_en(rd_en), .rd_ack(rd_ack), .rd_data(rd_data),
    .wr_address(wr_address), .wr_en(wr_en), .wr_data(wr_data), .wr_ack(wr_ack)
  );
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cyc = -100;
  int ack_dly = 0;
  int dstart = 3;
  int wcnt = 0;
  int both_err = 0;
  int ready_busy_err = 0;
  int stab_err = 0;
  int last_wr_cyc = -1;
  logic [15:0] rd_val = '0;
  logic hold = 1'b0;
  logic [2*AB+17:0] prev = '0;
  logic [2*AB+17:0] cur;
  logic [15:0] mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  logic [AB-1:0] rd_log [$];
  logic [AB+15:0] wr_log [$];
  logic [31:0] rsp_log [$];
  int rsp_cyc [$];
  function automatic logic [15:0] hh(int unsigned a);
    return 16'((a * 40503) ^ (a >> 3));
  endfunction
  function automatic logic [15:0] mem_rd(int unsigned a);
    return mem.exists(a) ? mem[a] : hh(a);
  endfunction
  function automatic logic [31:0] ref_word(int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : {hh(2 * w + 1), hh(2 * w)};
  endfunction
  assign ack_now = reset_n && (rd_en || wr_en) && (wcnt >= ack_dly);
  assign rd_ack = rd_en && ack_now;
  assign wr_ack = wr_en && ack_now;
  assign rd_data = (cyc >= ack_cyc + dstart && cyc <= ack_cyc + L) ? rd_val : ~rd_val;
  assign cur = {rd_en, wr_en, rd_en ? rd_address : {AB{1'b0}}, wr_en ? wr_address : {AB{1'b0}}, wr_en ? wr_data : 16'h0};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    wcnt <= (!reset_n || !(rd_en || wr_en) || ack_now) ? 0 : wcnt + 1;
    hold <= reset_n && ((rd_en && !rd_ack) || (wr_en && !wr_ack));
    prev <= cur;
    if (reset_n) begin
      if (hold && cur !== prev) stab_err++;
      if (rd_en && wr_en) both_err++;
      if (bus.req_ready && busy) ready_busy_err++;
      if (wr_en && wr_ack) begin
        wr_log.push_back({wr_address, wr_data});
        mem[wr_address] = wr_data;
        last_wr_cyc = cyc;
      end
      if (rd_en && rd_ack) begin
        rd_log.push_back(rd_address);
        ack_cyc <= cyc;
        rd_val <= mem_rd(rd_address);
      end
      if (bus.rsp_valid) begin
        rsp_log.push_back(bus.rsp_data);
        rsp_cyc.push_back(cyc);
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_req(input logic w, input logic [AB-2:0] a, input logic [31:0] d, output int acc);
    bus.req_write = w;
    bus.req_address = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    chk("accept_seen", acc >= 0, 1);
    tick();
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask
  task automatic check_read(input int unsigned a, input int acc, input string tag);
    chk({tag, "_nrd"}, rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk({tag, "_rd_lo_addr"}, rd_log[0], 2 * a);
      chk({tag, "_rd_hi_addr"}, rd_log[1], 2 * a + 1);
    end
    chk({tag, "_nrsp"}, rsp_log.size(), 1);
    if (rsp_log.size() == 1) begin
      chk({tag, "_data"}, rsp_log[0], ref_word(a));
      chk({tag, "_lat"}, rsp_cyc[0] - acc, 2 * (1 + ack_dly + L) + 1);
    end
    rd_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
  endtask
  task automatic check_write(input int unsigned a, input logic [31:0] d, input string tag);
    chk({tag, "_nwr"}, wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk({tag, "_wr_lo"}, wr_log[0], {23'(2 * a), 16'(d % 65536)});
      chk({tag, "_wr_hi"}, wr_log[1], {23'(2 * a + 1), 16'(d / 65536)});
    end
    wr_log.delete();
  endtask
  task automatic read_word(input int unsigned a, input string tag);
    int acc;
    do_req(1'b0, (AB-1)'(a), 32'h0, acc);
    wait_idle(tag);
    check_read(a, acc, tag);
  endtask
  task automatic write_word(input int unsigned a, input logic [31:0] d, input string tag);
    int acc;
    ref_mem[a] = d;
    do_req(1'b1, (AB-1)'(a), d, acc);
    wait_idle(tag);
    check_write(a, d, tag);
    chk({tag, "_norsp"}, rsp_log.size(), 0);
    chk({tag, "_ready"}, bus.req_ready, 1);
  endtask
  initial begin
    int acc, acc_w, acc_r, c0, n;
    logic [31:0] wd;
    logic [AB-1:0] t0, t1;
    reset_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_address = (AB-1)'(5);
    bus.req_wdata = 32'h0;
    tick();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy", busy, 0);
    tick();
    chk("rst_no_accept", busy, 0);
    reset_n = 1'b1;
    c0 = cyc;
    do_req(1'b0, (AB-1)'(5), 32'h0, acc);
    chk("first_accept_cycle", acc, c0);
    wait_idle("first_rd");
    check_read(5, acc, "first_rd");
    ack_dly = 1;
    write_word(32'h10, 32'hDEADBEEF, "wr10");
    read_word(32'h10, "rd10");
    ack_dly = 5;
    wd = $urandom;
    ref_mem[32'h33] = wd;
    do_req(1'b1, (AB-1)'(32'h33), wd, acc_w);
    do_req(1'b0, (AB-1)'(32'h33), 32'h0, acc_r);
    chk("b2b_write_done_first", last_wr_cyc < acc_r, 1);
    wait_idle("b2b");
    check_write(32'h33, wd, "b2b");
    check_read(32'h33, acc_r, "b2b");
    ack_dly = 0;
    do_req(1'b0, (AB-1)'(32'h3FFFFF), 32'h0, acc);
    wait_idle("max");
    if (rd_log.size() == 2) begin
      t0 = rd_log[0];
      t1 = rd_log[1];
      chk("max_bank", {t0[AB-1], t1[AB-1]}, 2'b11);
    end
    check_read(32'h3FFFFF, acc, "max");
    dstart = 3;
    do_req(1'b0, (AB-1)'(32'h77), 32'h0, acc);
    n = 0;
    while (rd_log.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid_reach_hi", rd_log.size(), 2);
    tick();
    reset_n = 1'b0;
    tick();
    chk("rst_mid_rd_en", rd_en, 0);
    chk("rst_mid_wr_en", wr_en, 0);
    chk("rst_mid_busy", busy, 0);
    reset_n = 1'b1;
    repeat (L + 6) tick();
    chk("rst_mid_norsp", rsp_log.size(), 0);
    rd_log.delete();
    rsp_log.delete();
    rsp_cyc.delete();
    read_word(5, "post_rst");
    dstart = L;
    for (int i = 0; i < 20; i++) begin
      int unsigned a;
      ack_dly = $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? 32'h3FFFF8 + $urandom_range(0, 7) : $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) write_word(a, $urandom, "rnd_wr");
      else read_word(a, "rnd_rd");
    end
    chk("never_both_en", both_err, 0);
    chk("ready_only_idle", ready_busy_err, 0);
    chk("en_stable_until_ack", stab_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/psram_word32_bridge.md
Name: psram_word32_bridge

Overview:
- Upstream neighbour of the 16-bit PSRAM controller; accepts 32-bit word read/write requests from the bridge/core side.
- Splits each request into two sequential 16-bit controller accesses: low half first, then high half.
- Drives the controller's rd_en/wr_en request lines and consumes its rd_ack/wr_ack.
- Samples controller read data a fixed latency after acceptance and returns one 32-bit read response.

Parameters:
- ADDRESS_BITS, 23, controller halfword address width including the bank bit; the upstream word address is ADDRESS_BITS-1 bits.
- RD_LATENCY, 4, cycles from the controller's rd_ack cycle to the cycle its rd_data is sampled; must be ≥ the controller's access length N (3 at 40 MHz / 72 ns).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  upstream request present.
- req_ready  out  1  bridge can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDRESS_BITS-1  32-bit word address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse: read data valid.
- rsp_data  out  32  read data; held until the next response.
- busy  out  1  a transaction is in flight (state ≠ IDLE).
- rd_address  out  ADDRESS_BITS  to controller.
- rd_en  out  1  to controller.
- rd_ack  in  1  from controller; combinational, asserted in the controller's idle cycle.
- rd_data  in  16  from controller.
- wr_address  out  ADDRESS_BITS  to controller.
- wr_en  out  1  to controller.
- wr_data  out  16  to controller.
- wr_ack  in  1  from controller.

Behaviour:
- Reset (reset_n low at a posedge):
  - state ← IDLE; rd_en = wr_en = 0; rsp_valid = 0; rsp_data = 0; latency counter = 0.
  - req_ready = 0 during the reset cycle, then 1 in IDLE.
- Accept: a request is taken when req_valid && req_ready. On acceptance, register req_address, req_write and req_wdata.
  - req_ready = 1 only in IDLE and not in reset, so there is one transaction outstanding at most.
- Halfword addressing: low half at {req_address, 1'b0}; high half at {req_address, 1'b1}. Bit ADDRESS_BITS-1 (bank select) comes straight from the word address.
- Write path:
  - IDLE → WR_LO: wr_en = 1, wr_address = low address, wr_data = wdata[15:0].
  - WR_LO → WR_HI on the cycle wr_ack = 1: wr_en stays 1, wr_address = high address, wr_data = wdata[31:16].
  - WR_HI → IDLE on wr_ack.
  - No response is generated for writes (posted).
- Read path:
  - IDLE → RD_LO: rd_en = 1 until rd_ack.
  - On rd_ack → RD_LO_WAIT: rd_en = 0 and the counter is loaded. Exactly RD_LATENCY cycles after the ack cycle, rd_data is captured into data[15:0].
  - RD_LO_WAIT → RD_HI (rd_en = 1) → RD_HI_WAIT → capture data[31:16].
  - Next cycle: rsp_valid = 1 for exactly one cycle, rsp_data = captured word, state → IDLE.
- Request/ack handshake:
  - en, address and data are registered and stable from assertion through the ack cycle.
  - en deasserts the cycle after ack unless the next half is issued immediately (write path).
  - rd_en and wr_en are never both 1.
  - No combinational path from ack to en.
- The controller ignores en while it is busy, so holding en across its busy period is legal. Acceptance is defined solely by ack.
- Latency:
  - Read: request accepted → rsp_valid = 2 × (1 + ack wait + RD_LATENCY) + 1 cycles minimum.
  - Write: accept → IDLE ≥ 1 + controller access time + 1.
- rsp_valid has no backpressure; the consumer must take it.
- Reset mid-operation:
  - Transaction abandoned; no rsp_valid is produced; en drops.
  - If the controller is mid-access, the next request's en is held until the controller returns to idle and acks, so no special handling is needed.
- Max word address (all ones) maps to halfwords 2^ADDRESS_BITS-2 and 2^ADDRESS_BITS-1 with no wrap into the other bank.

Decomposition:
- psram_pkg:
  - state_t enum (IDLE, WR_LO, WR_HI, RD_LO, RD_LO_WAIT, RD_HI, RD_HI_WAIT, RESP);
  - HALF_LO/HALF_HI constants;
  - the default RD_LATENCY constant shared with the controller instantiation.
- No sub-module; the latency counter is a local $clog2(RD_LATENCY+1)-bit down-counter.

Test Plan:
- Write 0xDEADBEEF to word 0x000010 with a controller model acking 1 cycle after en → wr_address 0x000020 with data 0xBEEF, then 0x000021 with 0xDEAD; no rsp_valid; req_ready returns 1.
- Read word 0x000010 with the model returning 0xBEEF/0xDEAD at rd_ack+3, RD_LATENCY = 4 → single rsp_valid pulse, rsp_data = 0xDEADBEEF.
- Write followed by a back-to-back read with the controller delaying acks 5 cycles → en held stable throughout; req_ready = 0 until the write finishes; rd_en and wr_en are never both high.
- Read of word 0x3FFFFF (ADDRESS_BITS = 23) → rd_address 0x7FFFFE then 0x7FFFFF; bank bit = 1 for both.
- reset_n low during RD_HI_WAIT → no rsp_valid; rd_en = wr_en = 0 the next cycle; a following read of word 0x5 returns correct data.
- req_valid held high with req_ready = 0 in the reset cycle → no acceptance until the first cycle after reset deasserts.
